// File: rtl/vga_fill_initiator.sv
// rtl/vga_fill_initiator.sv - rectangle-fill bus initiator for the VGA peripheral
//
// Ports:
//   clock, reset           single clock (also the bus clock), async active-high reset
//   cmd_valid/cmd_ready    fill command handshake; ready only while idle
//   cmd_x/cmd_y/cmd_w/cmd_h rectangle origin and size, clipped to MAX_W x MAX_H
//   cmd_color              pixel value, zero-extended to 32 bits on the bus
//   cmd_vsync              poll SCANLINE until it reads 0 before drawing
//   busy, done             engine active; one-cycle completion pulse
//   wr_*                   manager-side write channel (two-phase handshake)
//   rd_*                   manager-side read channel (SCANLINE polling)
module vga_fill_initiator #(
  parameter logic [31:0] VGA_ADDR = 32'h1000_0000,
  parameter int          MAX_W    = 640,
  parameter int          MAX_H    = 480,
  parameter int          XW       = 11,
  parameter int          YW       = 10
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [XW-1:0] cmd_x,
  input  logic [XW-1:0] cmd_w,
  input  logic [YW-1:0] cmd_y,
  input  logic [YW-1:0] cmd_h,
  input  logic [23:0]   cmd_color,
  input  logic          cmd_vsync,
  output logic          busy,
  output logic          done,
  output logic [31:0]   wr_addr,
  output logic [31:0]   wr_data,
  output logic [3:0]    wr_byteEn,
  output logic          wr_valid,
  input  logic          wr_ready,
  output logic [31:0]   rd_addr,
  output logic [3:0]    rd_byteEn,
  output logic          rd_valid,
  input  logic          rd_ready,
  input  logic [31:0]   rd_data
);

  localparam int          CW        = XW + YW;
  localparam logic [31:0] ADDR_X    = VGA_ADDR + 32'h04;
  localparam logic [31:0] ADDR_Y    = VGA_ADDR + 32'h08;
  localparam logic [31:0] ADDR_DATA = VGA_ADDR + 32'h0c;
  localparam logic [31:0] ADDR_SCAN = VGA_ADDR + 32'h1c;

  typedef enum logic [2:0] {
    S_IDLE, S_POLL, S_SET_X, S_SET_Y, S_DATA, S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic           wr_pending, rd_pending;
  logic           wr_done, rd_done;
  logic [XW-1:0]  x0;
  logic [YW-1:0]  y0;
  logic [23:0]    color;
  logic [YW:0]    h_c;
  logic [YW-1:0]  row;
  logic [CW-1:0]  col, col_last;
  logic           full_q;
  logic           col_end, row_end, scan_zero;

  // command decode (valid only while idle, used on the accept edge)
  logic [XW:0]    w_room, w_clip;
  logic [YW:0]    h_room, h_clip;
  logic           degenerate, full_cmd;
  logic [CW-1:0]  area;

  logic           issue_wr, issue_rd;
  logic [31:0]    wr_addr_d, wr_data_d;
  logic           rd_data_unused;

  assign rd_data_unused = ^rd_data[31:10];

  assign wr_done   = wr_pending & wr_ready;
  assign rd_done   = rd_pending & rd_ready;
  // Valid is masked on the ready cycle so the worker never sees a repeat.
  assign wr_valid  = wr_pending & ~wr_ready;
  assign rd_valid  = rd_pending & ~rd_ready;
  assign wr_byteEn = 4'hF;
  assign rd_byteEn = 4'hF;
  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

  assign scan_zero = (rd_data[9:0] == 10'd0);
  assign col_end   = (col == col_last);
  assign row_end   = ({1'b0, row} == h_c - (YW+1)'(1));

  always_comb begin
    w_room     = (XW+1)'(MAX_W) - {1'b0, cmd_x};
    h_room     = (YW+1)'(MAX_H) - {1'b0, cmd_y};
    w_clip     = ({1'b0, cmd_w} < w_room) ? {1'b0, cmd_w} : w_room;
    h_clip     = ({1'b0, cmd_h} < h_room) ? {1'b0, cmd_h} : h_room;
    degenerate = ({1'b0, cmd_x} >= (XW+1)'(MAX_W)) || ({1'b0, cmd_y} >= (YW+1)'(MAX_H)) ||
                 (cmd_w == '0) || (cmd_h == '0);
    // Full rows: the peripheral wraps x into the next row by itself.
    full_cmd   = (cmd_x == '0) && (w_clip == (XW+1)'(MAX_W));
    area       = CW'(w_clip) * CW'(h_clip);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Row advance is folded into the last DATA completion so the next row's
  // X write follows with no idle cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cmd_valid) state_d = degenerate ? S_DONE : (cmd_vsync ? S_POLL : S_SET_X);
      S_POLL:  if (rd_done && scan_zero) state_d = S_SET_X;
      S_SET_X: if (wr_done) state_d = S_SET_Y;
      S_SET_Y: if (wr_done) state_d = S_DATA;
      S_DATA:  if (wr_done && col_end) state_d = (full_q || row_end) ? S_DONE : S_SET_X;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // A new request is launched on the edge that enters (or re-enters) a bus
  // state, provided the previous one of that kind is finishing or absent.
  always_comb begin
    issue_wr  = 1'b0;
    wr_addr_d = wr_addr;
    wr_data_d = wr_data;
    if (!wr_pending || wr_done) begin
      case (state_d)
        S_SET_X: begin
          issue_wr  = 1'b1;
          wr_addr_d = ADDR_X;
          wr_data_d = {{(32-XW){1'b0}}, (state_q == S_IDLE) ? cmd_x : x0};
        end
        S_SET_Y: begin
          issue_wr  = 1'b1;
          wr_addr_d = ADDR_Y;
          wr_data_d = {{(32-YW){1'b0}}, y0 + row};
        end
        S_DATA: begin
          issue_wr  = 1'b1;
          wr_addr_d = ADDR_DATA;
          wr_data_d = {8'h00, color};
        end
        default: ;
      endcase
    end
    issue_rd = (state_d == S_POLL) && (!rd_pending || rd_done);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_pending <= 1'b0;
      rd_pending <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      rd_addr    <= '0;
      x0         <= '0;
      y0         <= '0;
      color      <= '0;
      h_c        <= '0;
      col_last   <= '0;
      full_q     <= 1'b0;
      row        <= '0;
      col        <= '0;
    end else begin
      if (wr_done) wr_pending <= 1'b0;
      if (rd_done) rd_pending <= 1'b0;
      if (issue_wr) begin
        wr_pending <= 1'b1;
        wr_addr    <= wr_addr_d;
        wr_data    <= wr_data_d;
      end
      if (issue_rd) begin
        rd_pending <= 1'b1;
        rd_addr    <= ADDR_SCAN;
      end
      if (cmd_ready && cmd_valid) begin
        x0       <= cmd_x;
        y0       <= cmd_y;
        color    <= cmd_color;
        h_c      <= h_clip;
        full_q   <= full_cmd;
        col_last <= full_cmd ? area - CW'(1) : CW'(w_clip) - CW'(1);
        row      <= '0;
        col      <= '0;
      end
      if (state_q == S_DATA && wr_done) begin
        if (col_end) begin
          col <= '0;
          row <= row + YW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_fill_initiator.sv
// tb/tb_vga_fill_initiator.sv - directed scoreboard bench for vga_fill_initiator
module tb_vga_fill_initiator;

  localparam logic [31:0] A_X    = 32'h1000_0004;
  localparam logic [31:0] A_Y    = 32'h1000_0008;
  localparam logic [31:0] A_DATA = 32'h1000_000c;
  localparam logic [31:0] A_SCAN = 32'h1000_001c;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [10:0] cmd_x = '0, cmd_w = '0;
  logic [9:0]  cmd_y = '0, cmd_h = '0;
  logic [23:0] cmd_color = '0;
  logic        cmd_vsync = 1'b0;
  logic        busy, done;
  logic [31:0] wr_addr, wr_data, rd_addr;
  logic [3:0]  wr_byteEn, rd_byteEn;
  logic        wr_valid, rd_valid;
  logic        wr_ready = 1'b0;
  logic        rd_ready = 1'b0;
  logic [31:0] rd_data = '0;

  vga_fill_initiator dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_w(cmd_w), .cmd_y(cmd_y), .cmd_h(cmd_h),
    .cmd_color(cmd_color), .cmd_vsync(cmd_vsync),
    .busy(busy), .done(done),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_byteEn(wr_byteEn),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_addr(rd_addr), .rd_byteEn(rd_byteEn), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_data(rd_data)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [63:0] exp_q[$];
  int          scan_q[$];

  int first_wv, wv_cnt, rv_cnt, both_cnt, done_cnt, done_cyc, n_data, n_rd, rd_at_first_wr;
  logic        s_wv = 1'b0, s_rv = 1'b0;
  logic [31:0] s_wa = '0, s_wd = '0, s_ra = '0;
  int          wph = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // mid-cycle snapshot of the DUT outputs and event counters
  always @(negedge clock) begin
    s_wv = wr_valid; s_wa = wr_addr; s_wd = wr_data;
    s_rv = rd_valid; s_ra = rd_addr;
    if (wr_valid) begin
      wv_cnt++;
      if (first_wv < 0) first_wv = cyc;
    end
    if (rd_valid) rv_cnt++;
    if (wr_valid && rd_valid) both_cnt++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // worker model: write = valid, act, ready; read = valid, ready
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ready <= 1'b0;
      rd_ready <= 1'b0;
      rd_data  <= '0;
      wph = 0;
    end else begin
      if (wr_ready) begin
        wr_ready <= 1'b0;
      end else if (wph != 0) begin
        wr_ready <= 1'b1;
        wph = 0;
      end else if (s_wv) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $error("FAIL unexpected_write observed addr=%h data=%h expected none", s_wa, s_wd);
        end else begin
          check("write", {s_wa, s_wd}, exp_q.pop_front());
        end
        if (rd_at_first_wr < 0) rd_at_first_wr = n_rd;
        if (s_wa == A_DATA) n_data++;
        wph = 1;
      end
      if (rd_ready) begin
        rd_ready <= 1'b0;
      end else if (s_rv) begin
        n_rd++;
        check("read_addr", {32'h0, s_ra}, {32'h0, A_SCAN});
        rd_ready <= 1'b1;
        rd_data  <= (scan_q.size() != 0) ? 32'(scan_q.pop_front()) : 32'h0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  task automatic clear_stats();
    first_wv = -1; wv_cnt = 0; rv_cnt = 0; both_cnt = 0; done_cnt = 0;
    done_cyc = -1; n_data = 0; n_rd = 0; rd_at_first_wr = -1;
  endtask

  task automatic push_rect(input int x, input int y, input int w, input int h, input logic [23:0] c);
    int wc, hc;
    if (x >= 640 || y >= 480 || w == 0 || h == 0) return;
    wc = (w < 640 - x) ? w : 640 - x;
    hc = (h < 480 - y) ? h : 480 - y;
    if (x == 0 && wc == 640) begin
      exp_q.push_back({A_X, 32'(x)});
      exp_q.push_back({A_Y, 32'(y)});
      repeat (wc * hc) exp_q.push_back({A_DATA, 8'h00, c});
    end else begin
      for (int r = 0; r < hc; r++) begin
        exp_q.push_back({A_X, 32'(x)});
        exp_q.push_back({A_Y, 32'(y + r)});
        repeat (wc) exp_q.push_back({A_DATA, 8'h00, c});
      end
    end
  endtask

  task automatic send(input int x, input int y, input int w, input int h,
                      input logic [23:0] c, input logic v, output int acc);
    @(negedge clock); #1;
    cmd_x = x[10:0]; cmd_y = y[9:0]; cmd_w = w[10:0]; cmd_h = h[9:0];
    cmd_color = c; cmd_vsync = v; cmd_valid = 1'b1;
    acc = cyc;
    @(negedge clock); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      tick(1);
      n++;
    end
    tests++;
    assert (done_cnt != 0)
    else begin
      fails++;
      $error("FAIL %s_timeout observed no done, required done within %0d cycles", tag, budget);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed no finish, required finish before 2 ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    clear_stats();

    // reset state
    tick(3);
    check("rst_wr_valid", wr_valid, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_byte_en", {wr_byteEn, rd_byteEn}, 8'hFF);
    reset = 1'b0;
    clear_stats();
    tick(10);
    check("idle_no_writes", wv_cnt, 0);
    check("idle_no_reads", rv_cnt, 0);
    check("idle_busy", busy, 0);

    // small rectangle: 10 writes of 3 cycles, done in the 31st cycle
    // counting the first wr_valid cycle as cycle 1
    clear_stats();
    push_rect(10, 20, 3, 2, 24'h00FF00);
    send(10, 20, 3, 2, 24'h00FF00, 1'b0, acc);
    wait_done(200, "rect");
    check("rect_ready_in_done", cmd_ready, 0);
    tick(1);
    check("rect_ready_after", cmd_ready, 1);
    tick(2);
    check("rect_latency", done_cyc - first_wv, 30);
    check("rect_first_valid", first_wv - acc, 1);
    check("rect_done_count", done_cnt, 1);
    check("rect_leftover", exp_q.size(), 0);
    check("rect_data_writes", n_data, 6);

    // clipped at the bottom-right corner
    clear_stats();
    push_rect(638, 479, 5, 4, 24'h123456);
    send(638, 479, 5, 4, 24'h123456, 1'b0, acc);
    wait_done(200, "clip");
    tick(3);
    check("clip_data_writes", n_data, 2);
    check("clip_leftover", exp_q.size(), 0);
    check("clip_done_count", done_cnt, 1);

    // full width: one X, one Y, then continuous DATA
    clear_stats();
    push_rect(0, 100, 640, 2, 24'hA5A5A5);
    send(0, 100, 640, 2, 24'hA5A5A5, 1'b0, acc);
    wait_done(5000, "full");
    tick(3);
    check("full_data_writes", n_data, 1280);
    check("full_leftover", exp_q.size(), 0);
    check("full_latency", done_cyc - first_wv, 3 * (2 + 1280));

    // degenerate commands
    clear_stats();
    send(5, 5, 0, 3, 24'h0000FF, 1'b0, acc);
    tick(3);
    check("deg_w0_done_at", done_cyc - acc, 1);
    check("deg_w0_done_count", done_cnt, 1);
    check("deg_w0_bus", wv_cnt + rv_cnt, 0);
    clear_stats();
    send(700, 5, 5, 5, 24'h0000FF, 1'b0, acc);
    tick(3);
    check("deg_x700_done_at", done_cyc - acc, 1);
    check("deg_x700_done_count", done_cnt, 1);
    check("deg_x700_bus", wv_cnt + rv_cnt, 0);

    // vsync poll, then reset during the second DATA write
    clear_stats();
    scan_q = '{5, 3, 0};
    push_rect(5, 6, 3, 1, 24'h0F0F0F);
    send(5, 6, 3, 1, 24'h0F0F0F, 1'b1, acc);
    for (int n = 0; n < 200 && n_data < 2; n++) tick(1);
    check("vs_reads", n_rd, 3);
    check("vs_reads_before_write", rd_at_first_wr, 3);
    check("vs_rd_valid_cycles", rv_cnt, 3);
    check("vs_data2_valid", wr_valid, 1);
    reset = 1'b1;
    #1;
    check("vs_async_wr_valid", wr_valid, 0);
    check("vs_async_busy", busy, 0);
    check("vs_async_done", done, 0);
    check("vs_async_ready", cmd_ready, 1);
    check("vs_async_wr_addr", wr_addr, 0);
    tick(2);
    reset = 1'b0;
    exp_q.delete();
    tick(6);
    check("vs_no_done", done_cnt, 0);
    check("vs_ready_after", cmd_ready, 1);
    check("vs_idle_after", busy, 0);
    check("never_both_valid", both_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
